weight_loader: RTL and testbench



---
 rtl/weight_loader.sv | 162 ++++++++++++++++
 tb/tb_weight_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : weight_loader                                                     |
// | Purpose : Streams signed weights into N per-neuron RAM banks, neuron-major. |
// |           Optional checksum stage enabled by macro WEIGHT_CHECKSUM_EN.      |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module weight_loader #(
    parameter int D  = 16,
    parameter int L  = 784,
    parameter int N  = 2,
    parameter int AW = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [D-1:0] s_data,
    output logic [N-1:0]        wren,
    output logic [AW-1:0]       addr,
    output logic [D-1:0]        wdata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int WW = (L > 1) ? $clog2(L) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WW-1:0] WORD_LAST = WW'(L - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(N - 1);

`ifdef WEIGHT_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [BW-1:0]   bank_q, bank_d;
    logic [N-1:0]    wren_q, wren_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [D-1:0]    wdata_q, wdata_d;
    logic            xfer;

`ifdef WEIGHT_CHECKSUM_EN
    logic [D-1:0]    sum_q, sum_d;
    logic            err_q, err_d;

    assign s_ready = (state_q == LOAD) || (state_q == CHECK);
    assign err     = err_q;
`else
    assign s_ready = (state_q == LOAD);
    assign err     = 1'b0;
`endif

    assign busy  = s_ready;
    assign done  = (state_q == DONE);
    assign wren  = wren_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign xfer  = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            bank_q  <= '0;
            wren_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef WEIGHT_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bank_q  <= bank_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef WEIGHT_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bank_d  = bank_q;
        wren_d  = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef WEIGHT_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    word_d  = '0;
                    bank_d  = '0;
`ifdef WEIGHT_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (xfer) begin
                    wren_d  = N'(1) << bank_q;
                    addr_d  = AW'(word_q);
                    wdata_d = s_data;
`ifdef WEIGHT_CHECKSUM_EN
                    sum_d   = sum_q + s_data;
`endif
                    if (word_q == WORD_LAST) begin
                        word_d = '0;
                        // Last word of the last bank closes the weight stream
                        if (bank_q == BANK_LAST) begin
`ifdef WEIGHT_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = DONE;
`endif
                        end else begin
                            bank_d = bank_q + 1'b1;
                        end
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
`ifdef WEIGHT_CHECKSUM_EN
            CHECK: begin
                // Checksum word is compared only, never written to RAM
                if (xfer) begin
                    err_d   = (s_data != sum_q);
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// Directed bench for weight_loader (L=4, N=2) with a write scoreboard and RAM model.
module tb_weight_loader;

    localparam int D  = 16;
    localparam int L  = 4;
    localparam int N  = 2;
    localparam int AW = 20;

    typedef struct packed {
        logic [7:0]  bank;
        logic [19:0] addr;
        logic [15:0] data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                s_valid;
    logic                s_ready;
    logic signed [D-1:0] s_data;
    logic [N-1:0]        wren;
    logic [AW-1:0]       addr;
    logic [D-1:0]        wdata;
    logic                busy;
    logic                done;
    logic                err;

    int          checks   = 0;
    int          failures = 0;
    int          wr_cnt   = 0;
    bit          mon_en   = 1'b0;
    exp_t        sb[$];
    logic [15:0] mem [N][L];
    logic [15:0] wv  [N*L];
    logic [15:0] cs_word;
    logic        exp_err;

    weight_loader #(.D(D), .L(L), .N(N), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .wren    (wren),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every RAM write must match the oldest outstanding accepted word
    always @(negedge clk) begin
        if (mon_en && wren !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {30'd0, wren}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_wren", {30'd0, wren}, 32'd1 << e.bank);
                chk("wr_addr", {12'd0, addr}, {12'd0, e.addr});
                chk("wr_data", {16'd0, wdata}, {16'd0, e.data});
                if (addr < AW'(L) && e.bank < 8'(N))
                    mem[e.bank][addr[1:0]] = wdata;
                wr_cnt++;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input int gap, input bit push, input int bank, input int a);
        bit ok;
        exp_t e;
        ok = 1'b0;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready) begin
                if (push) begin
                    e.bank = 8'(bank);
                    e.addr = 20'(a);
                    e.data = d;
                    sb.push_back(e);
                end
                chk("busy_in_load", {31'd0, busy}, 32'd1);
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_load(input int maxgap, input bit mid_start);
        bit seen;
        int gap;
        for (int b = 0; b < N; b++)
            for (int a = 0; a < L; a++) mem[b][a] = 16'hDEAD;
        wr_cnt = 0;
        pulse_start();
        @(negedge clk);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < N*L; k++) begin
            if (maxgap == 0) gap = 0;
            else gap = (k % 2 == 1) ? 1 : int'($urandom_range(0, maxgap));
            if (mid_start && k == 3) begin
                pulse_start();
                @(negedge clk);
                chk("mid_start_busy", {31'd0, busy}, 32'd1);
                @(posedge clk); #1;
            end
            send_word(wv[k], gap, 1'b1, k / L, k % L);
        end
`ifdef WEIGHT_CHECKSUM_EN
        @(negedge clk);
        chk("check_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        send_word(cs_word, 0, 1'b0, 0, 0);
`endif
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fin_done", {31'd0, done}, 32'd1);
        chk("fin_busy", {31'd0, busy}, 32'd0);
        chk("fin_ready", {31'd0, s_ready}, 32'd0);
        chk("fin_err", {31'd0, err}, {31'd0, exp_err});
        chk("fin_wr_cnt", 32'(wr_cnt), 32'(N*L));
        chk("fin_sb_empty", 32'(sb.size()), 32'd0);
        for (int b = 0; b < N; b++)
            for (int a = 0; a < L; a++)
                chk($sformatf("ram_b%0d_a%0d", b, a), {16'd0, mem[b][a]}, {16'd0, wv[b*L+a]});
        // Words offered after completion must be refused
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            chk("done_refuse", {31'd0, s_ready}, 32'd0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("done_no_write", 32'(wr_cnt), 32'(N*L));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        cs_word = 16'd36; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_wren", {30'd0, wren}, 32'd0);
        chk("rst_addr", {12'd0, addr}, 32'd0);
        chk("rst_wdata", {16'd0, wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Continuous stream 1..8
        for (int k = 0; k < N*L; k++) wv[k] = 16'(k + 1);
        run_load(0, 1'b0);

        // Same stream with gaps
        run_load(5, 1'b0);

        // Reset mid-load while a transfer is offered on the reset edge
        pulse_start();
        for (int k = 0; k < 4; k++) send_word(wv[k], 0, 1'b1, k / L, k % L);
        s_valid = 1'b1;
        s_data  = 16'd5;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("midrst_wren", {30'd0, wren}, 32'd0);
        chk("midrst_addr", {12'd0, addr}, 32'd0);
        chk("midrst_wdata", {16'd0, wdata}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < N*L; k++) wv[k] = 16'(-(k + 1));
        cs_word = 16'hFFDC;
        run_load(0, 1'b0);

        // start pulse in the middle of a load is ignored
        for (int k = 0; k < N*L; k++) wv[k] = 16'(k + 1);
        cs_word = 16'd36;
        run_load(2, 1'b1);

`ifdef WEIGHT_CHECKSUM_EN
        cs_word = 16'd35; exp_err = 1'b1;
        run_load(0, 1'b0);
        cs_word = 16'd36; exp_err = 1'b0;
        run_load(0, 1'b0);
        for (int k = 0; k < N*L; k++) wv[k] = 16'd0;
        wv[0] = 16'h7FFF;
        wv[1] = 16'h7FFF;
        cs_word = 16'hFFFE; exp_err = 1'b0;
        run_load(0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
